// File: rtl/csr_byte_master_pkg.sv
// Shared constants and FSM state type for the CSR byte-stream bus master.
package csr_byte_master_pkg;

    localparam logic [7:0]  CMD_WRITE    = 8'h01;
    localparam logic [7:0]  CMD_READ     = 8'h02;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [2:0] {
        StCmd,
        StAddr,
        StDhi,
        StDlo,
        StWr,
        StRd,
        StTxh,
        StTxl
    } state_e;

    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/csr_byte_master.sv
// Host byte stream to CSR bus master: WRITE = 01,ADDR,DHI,DLO; READ = 02,ADDR -> reply DHI,DLO.
// Optional read timeout enabled by defining CSR_BYTE_MASTER_TIMEOUT_EN.
module csr_byte_master
    import csr_byte_master_pkg::*;
#(
    parameter int unsigned CSR_ADDR_W     = 8,
    parameter int unsigned CSR_DATA_W     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic                  csr_wen,
    output logic [CSR_DATA_W-1:0] csr_wdata,
    output logic                  csr_ren,
    input  logic                  csr_rvalid,
    input  logic [CSR_DATA_W-1:0] csr_rdata,
    output logic                  proto_err
);

    state_e                  state_q, state_d;
    logic                    is_read_q, is_read_d;
    logic [CSR_ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]              dhi_q, dhi_d;
    logic [7:0]              dlo_q, dlo_d;
    logic [CSR_DATA_W-1:0]   rdata_q, rdata_d;
    logic                    proto_err_q, proto_err_d;
    logic                    rx_state;
    logic                    rx_fire;

    assign rx_state = (state_q == StCmd) || (state_q == StAddr) ||
                      (state_q == StDhi) || (state_q == StDlo);
    // Held low while in reset so no byte is consumed before the FSM is known.
    assign rx_ready  = rx_state & ~rst;
    assign rx_fire   = rx_valid & rx_ready;
    assign proto_err = proto_err_q;

`ifdef CSR_BYTE_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        dhi_d       = dhi_q;
        dlo_d       = dlo_q;
        rdata_d     = rdata_q;
        proto_err_d = 1'b0;
        csr_wen     = 1'b0;
        csr_ren     = 1'b0;
        csr_addr    = '0;
        csr_wdata   = '0;
        tx_valid    = 1'b0;
        tx_data     = '0;
`ifdef CSR_BYTE_MASTER_TIMEOUT_EN
        cnt_d       = '0;
`endif

        unique case (state_q)
            StCmd: begin
                if (rx_fire) begin
                    if (is_known_cmd(rx_data)) begin
                        is_read_d = (rx_data == CMD_READ);
                        state_d   = StAddr;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    addr_d  = rx_data[CSR_ADDR_W-1:0];
                    state_d = is_read_q ? StRd : StDhi;
                end
            end
            StDhi: begin
                if (rx_fire) begin
                    dhi_d   = rx_data;
                    state_d = StDlo;
                end
            end
            StDlo: begin
                if (rx_fire) begin
                    dlo_d   = rx_data;
                    state_d = StWr;
                end
            end
            StWr: begin
                csr_wen   = 1'b1;
                csr_addr  = addr_q;
                csr_wdata = {dhi_q, dlo_q};
                state_d   = StCmd;
            end
            StRd: begin
                csr_ren  = 1'b1;
                csr_addr = addr_q;
                if (csr_rvalid) begin
                    rdata_d = csr_rdata;
                    state_d = StTxh;
                end
`ifdef CSR_BYTE_MASTER_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (timeout) begin
                        rdata_d     = TIMEOUT_DATA;
                        proto_err_d = 1'b1;
                        state_d     = StTxh;
                    end
                end
`endif
            end
            StTxh: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[CSR_DATA_W-1 -: 8];
                if (tx_ready) state_d = StTxl;
            end
            StTxl: begin
                tx_valid = 1'b1;
                tx_data  = rdata_q[7:0];
                if (tx_ready) state_d = StCmd;
            end
            default: state_d = StCmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StCmd;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            dhi_q       <= dhi_d;
            dlo_q       <= dlo_d;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef CSR_BYTE_MASTER_TIMEOUT_EN
    // Counter only advances in RD, so it is already zero on every entry.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_csr_byte_master.sv
// Directed, table-driven bench for csr_byte_master with a simple CSR slave model.
module tb_csr_byte_master;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  csr_addr;
    logic        csr_wen;
    logic [15:0] csr_wdata;
    logic        csr_ren;
    logic        csr_rvalid;
    logic [15:0] csr_rdata;
    logic        proto_err;

    always #5 clk = ~clk;

    csr_byte_master #(
        .CSR_ADDR_W    (8),
        .CSR_DATA_W    (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .csr_addr  (csr_addr),
        .csr_wen   (csr_wen),
        .csr_wdata (csr_wdata),
        .csr_ren   (csr_ren),
        .csr_rvalid(csr_rvalid),
        .csr_rdata (csr_rdata),
        .proto_err (proto_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from DUT updates.
    int         wen_cnt  = 0;
    int         perr_cnt = 0;
    int         ren_cyc  = 0;
    int         stab_err = 0;
    int         out_bad  = 0;
    logic [7:0]  txq[$];
    logic [7:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    logic        hold_prev = 1'b0;
    logic [7:0]  data_prev = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (csr_wen) begin
                wen_cnt++;
                wq_addr.push_back(csr_addr);
                wq_data.push_back(csr_wdata);
            end
            if (proto_err) perr_cnt++;
            if (csr_ren) ren_cyc++;
            if (!tx_valid && tx_data != 8'h00) out_bad++;
            if (!csr_wen && csr_wdata != 16'h0000) out_bad++;
            if (csr_wen && csr_ren) out_bad++;
            if (hold_prev && (!tx_valid || tx_data != data_prev)) stab_err++;
            hold_prev = tx_valid && !tx_ready;
            data_prev = tx_data;
            if (tx_valid && tx_ready) txq.push_back(tx_data);
        end
    end

    // CSR slave model: answers on the rd_delay-th cycle of csr_ren (0 = never).
    int          rd_delay = 0;
    logic [15:0] rd_value = 16'h0000;
    logic        spurious = 1'b0;

    initial begin
        int cnt = 0;
        csr_rvalid = 1'b0;
        csr_rdata  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (csr_ren) begin
                cnt++;
                if (rd_delay != 0 && cnt == rd_delay) begin
                    csr_rvalid = 1'b1;
                    csr_rdata  = rd_value;
                end else begin
                    csr_rvalid = 1'b0;
                    csr_rdata  = 16'h0000;
                end
            end else begin
                cnt        = 0;
                csr_rvalid = spurious;
                csr_rdata  = spurious ? 16'h5555 : 16'h0000;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at posedge+1 right after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!rx_ready) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_tx(input int want, input int budget);
        int c = 0;
        while (txq.size() < want && c < budget) begin
            tick(1);
            c++;
        end
    endtask

    function automatic logic [7:0] txb(input int idx);
        return (txq.size() > idx) ? txq[idx] : 8'h00;
    endfunction

    typedef struct {
        int          kind;       // 0 write, 1 read, 2 raw byte
        logic [7:0]  b0;
        logic [7:0]  addr;
        logic [15:0] data;
        int          dly;
        int          exp_wen;
        logic [7:0]  exp_addr;
        logic [15:0] exp_wdata;
        int          exp_perr;
        int          exp_ren;
        int          exp_ntx;
        logic [7:0]  exp_tx0;
        logic [7:0]  exp_tx1;
    } vec_t;

    function automatic vec_t mk(input int k, input logic [7:0] b0, input logic [7:0] a,
                                input logic [15:0] d, input int dly, input int ew,
                                input logic [7:0] ea, input logic [15:0] ed, input int ep,
                                input int er, input int en, input logic [7:0] t0,
                                input logic [7:0] t1);
        vec_t v;
        v.kind = k; v.b0 = b0; v.addr = a; v.data = d; v.dly = dly;
        v.exp_wen = ew; v.exp_addr = ea; v.exp_wdata = ed; v.exp_perr = ep;
        v.exp_ren = er; v.exp_ntx = en; v.exp_tx0 = t0; v.exp_tx1 = t1;
        return v;
    endfunction

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, p0, r0, t0, bad;

        vecs[0] = mk(0, 8'h00, 8'h01, 16'h00AA, 0, 1, 8'h01, 16'h00AA, 0, 0, 0, 8'h00, 8'h00);
        vecs[1] = mk(1, 8'h00, 8'h23, 16'h0233, 5, 0, 8'h00, 16'h0000, 0, 5, 2, 8'h02, 8'h33);
        vecs[2] = mk(2, 8'h55, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 8'h00);
        vecs[3] = mk(1, 8'h00, 8'h07, 16'hBEEF, 1, 0, 8'h00, 16'h0000, 0, 1, 2, 8'hBE, 8'hEF);
        vecs[4] = mk(0, 8'h00, 8'hFF, 16'h1234, 0, 1, 8'hFF, 16'h1234, 0, 0, 0, 8'h00, 8'h00);
        vecs[5] = mk(2, 8'h03, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 8'h00);
        vecs[6] = mk(1, 8'h00, 8'h80, 16'h8001, 3, 0, 8'h00, 16'h0000, 0, 3, 2, 8'h80, 8'h01);
        vecs[7] = mk(0, 8'h00, 8'h00, 16'hFFFF, 0, 1, 8'h00, 16'hFFFF, 0, 0, 0, 8'h00, 8'h00);
        vecs[8] = mk(2, 8'h00, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 8'h00);

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;

        // Reset values
        tick(3);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_csr_addr", 32'(csr_addr), 32'd0);
        check("rst_csr_wen", 32'(csr_wen), 32'd0);
        check("rst_csr_wdata", 32'(csr_wdata), 32'd0);
        check("rst_csr_ren", 32'(csr_ren), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        rst = 1'b0;
        tick(1);
        check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

        // Table-driven frames
        for (int i = 0; i < NV; i++) begin
            w0 = wen_cnt; p0 = perr_cnt; r0 = ren_cyc; t0 = txq.size();
            rd_delay = vecs[i].dly;
            rd_value = vecs[i].data;
            if (vecs[i].kind == 0) begin
                send_byte(8'h01);
                send_byte(vecs[i].addr);
                send_byte(vecs[i].data[15:8]);
                send_byte(vecs[i].data[7:0]);
            end else if (vecs[i].kind == 1) begin
                send_byte(8'h02);
                send_byte(vecs[i].addr);
            end else begin
                send_byte(vecs[i].b0);
            end
            wait_tx(t0 + vecs[i].exp_ntx, 100);
            tick(4);
            check($sformatf("v%0d_wen_cnt", i), 32'(wen_cnt - w0), 32'(vecs[i].exp_wen));
            check($sformatf("v%0d_wen_addr", i),
                  32'((wq_addr.size() > w0) ? wq_addr[w0] : 8'h00), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_wen_wdata", i),
                  32'((wq_data.size() > w0) ? wq_data[w0] : 16'h0000), 32'(vecs[i].exp_wdata));
            check($sformatf("v%0d_proto_err", i), 32'(perr_cnt - p0), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_ren_cycles", i), 32'(ren_cyc - r0), 32'(vecs[i].exp_ren));
            check($sformatf("v%0d_ntx", i), 32'(txq.size() - t0), 32'(vecs[i].exp_ntx));
            check($sformatf("v%0d_tx0", i), 32'(txb(t0)), 32'(vecs[i].exp_tx0));
            check($sformatf("v%0d_tx1", i), 32'(txb(t0 + 1)), 32'(vecs[i].exp_tx1));
            check($sformatf("v%0d_idle", i), 32'(rx_ready), 32'd1);
        end

        // Write strobe timing: csr_wen in the cycle right after the DLO handshake edge
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h12);
        send_byte(8'h34);
        check("wr_wen_now", 32'(csr_wen), 32'd1);
        check("wr_addr_now", 32'(csr_addr), 32'h5A);
        check("wr_wdata_now", 32'(csr_wdata), 32'h1234);
        check("wr_rx_ready_now", 32'(rx_ready), 32'd0);
        tick(1);
        check("wr_wen_after", 32'(csr_wen), 32'd0);
        check("wr_wdata_after", 32'(csr_wdata), 32'd0);
        check("wr_addr_after", 32'(csr_addr), 32'd0);

        // proto_err is a single pulse in the cycle after the bad byte
        send_byte(8'h77);
        check("perr_pulse", 32'(proto_err), 32'd1);
        check("perr_stay_cmd", 32'(rx_ready), 32'd1);
        tick(1);
        check("perr_pulse_end", 32'(proto_err), 32'd0);

        // Host back-pressure: tx byte held, no rx accepted
        tx_ready = 1'b0;
        rd_delay = 2;
        rd_value = 16'hC35A;
        t0 = txq.size();
        w0 = wen_cnt;
        send_byte(8'h02);
        send_byte(8'h10);
        bad = 0;
        while (!tx_valid && bad < 50) begin
            tick(1);
            bad++;
        end
        check("bp_tx_valid", 32'(tx_valid), 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h01;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!tx_valid || tx_data != 8'hC3 || rx_ready) bad++;
            tick(1);
        end
        check("bp_hold_errors", 32'(bad), 32'd0);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        wait_tx(t0 + 2, 50);
        tick(3);
        check("bp_ntx", 32'(txq.size() - t0), 32'd2);
        check("bp_tx0", 32'(txb(t0)), 32'hC3);
        check("bp_tx1", 32'(txb(t0 + 1)), 32'h5A);
        check("bp_no_write", 32'(wen_cnt - w0), 32'd0);

        // csr_rvalid outside a read is ignored
        t0 = txq.size();
        spurious = 1'b1;
        tick(3);
        spurious = 1'b0;
        tick(2);
        check("spur_ntx", 32'(txq.size() - t0), 32'd0);
        check("spur_idle", 32'(rx_ready), 32'd1);

        // Reset during an outstanding read
        rd_delay = 0;
        t0 = txq.size();
        send_byte(8'h02);
        send_byte(8'h30);
        tick(2);
        check("rstrd_ren_before", 32'(csr_ren), 32'd1);
        check("rstrd_addr_before", 32'(csr_addr), 32'h30);
        rst = 1'b1;
        tick(1);
        check("rstrd_ren_after", 32'(csr_ren), 32'd0);
        check("rstrd_rx_ready_in_rst", 32'(rx_ready), 32'd0);
        rst = 1'b0;
        tick(5);
        check("rstrd_no_tx", 32'(txq.size() - t0), 32'd0);
        check("rstrd_tx_valid", 32'(tx_valid), 32'd0);
        w0 = wen_cnt;
        send_byte(8'h01);
        send_byte(8'hA1);
        send_byte(8'h00);
        send_byte(8'h01);
        tick(3);
        check("rstrd_wr_cnt", 32'(wen_cnt - w0), 32'd1);
        check("rstrd_wr_addr", 32'((wq_addr.size() > w0) ? wq_addr[w0] : 8'h00), 32'hA1);
        check("rstrd_wr_data", 32'((wq_data.size() > w0) ? wq_data[w0] : 16'h0000), 32'h0001);

`ifdef CSR_BYTE_MASTER_TIMEOUT_EN
        // Read timeout: csr_ren for TO cycles, reply DEAD, one proto_err
        rd_delay = 0;
        t0 = txq.size();
        r0 = ren_cyc;
        p0 = perr_cnt;
        send_byte(8'h02);
        send_byte(8'h44);
        wait_tx(t0 + 2, 100);
        tick(3);
        check("to_ren_cycles", 32'(ren_cyc - r0), 32'(TO));
        check("to_ntx", 32'(txq.size() - t0), 32'd2);
        check("to_tx0", 32'(txb(t0)), 32'hDE);
        check("to_tx1", 32'(txb(t0 + 1)), 32'hAD);
        check("to_proto_err", 32'(perr_cnt - p0), 32'd1);
`endif

        check("tx_stable_while_stalled", 32'(stab_err), 32'd0);
        check("outputs_zero_when_idle", 32'(out_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
